// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
//   Shares one single-port frame-buffer BRAM between the camera write path
//   and the display read path. Reads win by default so scan-out never
//   stalls; a starvation counter forces one write grant after MAX_WAIT
//   consecutive denied writer cycles.
//
// Optional feature macro: FB_ARB_RANGECHK_EN
//   Defined   -> granted requests with addr >= BRAM_DEPTH are not issued to
//                the BRAM and set sticky o_err until reset.
//   Undefined -> every granted request is issued; o_err is tied 0.
//
// Ports
//   i_clk, i_rstn          clock, asynchronous active-low reset
//   i_wr_req/addr/data     writer request, o_wr_gnt combinational accept
//   i_rd_req/addr          reader request, o_rd_gnt combinational accept
//   o_rd_data, o_rd_valid  read return (2 cycles after read grant)
//   o_bram_en/we/addr/wdata registered BRAM command
//   i_bram_rdata           BRAM read data, 1-cycle latency after o_bram_en
//   o_err                  sticky out-of-range flag
module fb_port_arbiter #(
  parameter int BRAM_WIDTH = 12,
  parameter int BRAM_DEPTH = 307200,
  parameter int MAX_WAIT   = 4,
  localparam int AW        = $clog2(BRAM_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_wr_req,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [BRAM_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_gnt,
  input  logic                  i_rd_req,
  input  logic [AW-1:0]         i_rd_addr,
  output logic                  o_rd_gnt,
  output logic [BRAM_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_bram_en,
  output logic                  o_bram_we,
  output logic [AW-1:0]         o_bram_addr,
  output logic [BRAM_WIDTH-1:0] o_bram_wdata,
  input  logic [BRAM_WIDTH-1:0] i_bram_rdata,
  output logic                  o_err
);

  typedef enum logic {S_RD_PRI = 1'b0, S_WR_FORCE = 1'b1} state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    rd_gnt, wr_gnt;
  logic [AW-1:0]           cmd_addr;
  logic                    in_range;
  logic                    issue;

  logic                    en_q, en_d;
  logic                    we_q, we_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [BRAM_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    vld_p0_q, vld_p0_d;
  logic                    vld_p1_q, vld_p1_d;
  logic                    err_q, err_d;

`ifdef FB_ARB_RANGECHK_EN
  localparam logic [AW:0] DEPTH_C = (AW+1)'(BRAM_DEPTH);
`endif

  // Arbitration, starvation counter and next-command computation.
  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    case (state_q)
      S_RD_PRI: begin
        if (i_rd_req)      rd_gnt = 1'b1;
        else if (i_wr_req) wr_gnt = 1'b1;
      end
      S_WR_FORCE: begin
        // Forced slot: the writer wins outright; if it has gone away the
        // reader keeps its normal priority.
        if (i_wr_req)      wr_gnt = 1'b1;
        else if (i_rd_req) rd_gnt = 1'b1;
      end
      default: ;
    endcase
    // Grants stay low while reset is held.
    if (!i_rstn) begin
      rd_gnt = 1'b0;
      wr_gnt = 1'b0;
    end

    cnt_d   = (i_wr_req && !wr_gnt) ? cnt_q + 4'd1 : 4'd0;
    state_d = (cnt_d == MAX_WAIT_C) ? S_WR_FORCE : S_RD_PRI;

    cmd_addr = wr_gnt ? i_wr_addr : i_rd_addr;
`ifdef FB_ARB_RANGECHK_EN
    in_range = ({1'b0, cmd_addr} < DEPTH_C);
    err_d    = err_q | ((rd_gnt | wr_gnt) & ~in_range);
`else
    in_range = 1'b1;
    err_d    = 1'b0;
`endif
    issue = (rd_gnt | wr_gnt) & in_range;

    en_d     = issue;
    we_d     = issue & wr_gnt;
    addr_d   = issue ? cmd_addr : addr_q;
    wdata_d  = (issue && wr_gnt) ? i_wr_data : wdata_q;
    vld_p0_d = issue & rd_gnt;
    vld_p1_d = vld_p0_q;
  end

  // Stage p0: command register toward the BRAM, first read-valid stage.
  // Stage p1: read data returns from the BRAM alongside vld_p1.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= S_RD_PRI;
      cnt_q    <= 4'd0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      err_q    <= err_d;
    end
  end

  assign o_rd_gnt     = rd_gnt;
  assign o_wr_gnt     = wr_gnt;
  assign o_bram_en    = en_q;
  assign o_bram_we    = we_q;
  assign o_bram_addr  = addr_q;
  assign o_bram_wdata = wdata_q;
  assign o_rd_valid   = vld_p1_q;
  assign o_rd_data    = i_bram_rdata;
  assign o_err        = err_q;

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Arbitrates a single-port frame-buffer BRAM between the camera write path (FIFO drain, pixel writes) and the display read path (pixel fetch). Reads have priority so scan-out never stalls. A starvation counter forces a write grant after a bounded number of denied cycles. The block sits between the write-side stream logic, the display read-out logic and the BRAM primitive, and drives all BRAM control signals.

## Interface
- BRAM_WIDTH, 12, pixel data width (RGB444)
- BRAM_DEPTH, 307200, words in BRAM (640x480); AW = $clog2(BRAM_DEPTH) = 19
- MAX_WAIT, 4, consecutive denied writer cycles before a write is forced (1..15)

Clock and reset: one clock; reset is asynchronous and active-low.
- i_clk  in  1  system clock (125 MHz domain)
- i_rstn  in  1  asynchronous active-low reset
- i_wr_req  in  1  writer requests a BRAM write this cycle
- i_wr_addr  in  AW  write address
- i_wr_data  in  BRAM_WIDTH  write data
- o_wr_gnt  out  1  combinational; write accepted this cycle
- i_rd_req  in  1  reader requests a BRAM read this cycle
- i_rd_addr  in  AW  read address
- o_rd_gnt  out  1  combinational; read accepted this cycle
- o_rd_data  out  BRAM_WIDTH  read data, valid when o_rd_valid
- o_rd_valid  out  1  read data strobe
- o_bram_en  out  1  registered BRAM enable
- o_bram_we  out  1  registered BRAM write enable
- o_bram_addr  out  AW  registered BRAM address
- o_bram_wdata  out  BRAM_WIDTH  registered BRAM write data
- i_bram_rdata  in  BRAM_WIDTH  BRAM read data, 1-cycle latency after o_bram_en
- o_err  out  1  sticky out-of-range flag (see Configuration)

## Operation
- FSM states: S_RD_PRI (reset state) and S_WR_FORCE.
- S_RD_PRI: i_rd_req=1 -> o_rd_gnt=1, o_wr_gnt=0. i_rd_req=0 and i_wr_req=1 -> o_wr_gnt=1.
- Starvation counter (4 bits, reset 0): increments when i_wr_req=1 and o_wr_gnt=0; clears whenever o_wr_gnt=1 or i_wr_req=0. When it reaches MAX_WAIT, the next state is S_WR_FORCE.
- S_WR_FORCE: if i_wr_req=1, o_wr_gnt=1 and o_rd_gnt=0 regardless of i_rd_req; the counter clears and the FSM returns to S_RD_PRI next cycle. If i_wr_req=0, return to S_RD_PRI with no grant forced.
- At most one grant per cycle; a grant is never asserted without its request.
- A granted command is registered into o_bram_* at the next edge: en=1, we=write, addr/wdata from the winner. With no grant: en=0, we=0, and addr/wdata hold their previous values.
- Read pipeline: a 2-stage valid shift register. o_rd_data = i_bram_rdata, passed through combinationally.
- Addresses are AW bits and are not wrapped; address sequencing is the requesters' responsibility.

## Timing
- Grant to BRAM command: 1 cycle. Read grant in cycle N -> o_bram_en=1 in N+1 -> o_rd_valid=1 and o_rd_data valid in N+2.
- Back-to-back reads sustain 1 word/cycle. A writer facing continuous reads gets exactly 1 grant every MAX_WAIT+1 cycles.
- Reset values: o_bram_en=0, o_bram_we=0, o_bram_addr=0, o_bram_wdata=0, o_rd_valid=0, o_err=0, FSM=S_RD_PRI, counter=0. o_wr_gnt and o_rd_gnt are 0 during reset.
- Reset asserted mid-operation: all registers clear immediately; in-flight reads are dropped (no o_rd_valid).
- Simultaneous requests resolve as above; a denied requester holds its request and data stable until granted.

## Configuration
- FB_ARB_RANGECHK_EN defined: a request with addr >= BRAM_DEPTH is still granted but not issued (o_bram_en=0). It sets sticky o_err until reset. A denied out-of-range read produces no o_rd_valid.
- Undefined: no range check; all granted requests are issued; o_err is tied 0.

## Test plan
- Reset, then a read-only burst at addr 0..9, each granted -> o_bram_addr follows 0..9 one cycle later; o_rd_valid high cycles 2..11 with the BRAM model's data.
- Write-only: addr 307199, data 12'hABC -> o_wr_gnt the same cycle; next cycle o_bram_en=1, o_bram_we=1, addr 307199, wdata 12'hABC.
- Continuous reads plus continuous writes, MAX_WAIT=4 -> the writer is granted on cycles 5, 10, 15; the reader is denied exactly on those cycles; never two grants at once.
- i_wr_req drops after 3 denied cycles and is reasserted -> the counter restarts at 0; the next forced grant comes 5 cycles after reassertion.
- i_rstn low for 1 cycle while two reads are in flight -> o_rd_valid=0 immediately and no valid pulses after reset release; all o_bram_* are 0.
- With FB_ARB_RANGECHK_EN: read at addr 307200 -> o_rd_gnt=1, o_bram_en stays 0, o_err=1 and holds through later valid traffic until reset.
